// File: rtl/freq_meas_pkg.sv
// rtl/freq_meas_pkg.sv - shared types and defaults for the frequency measurement scheduler
package freq_meas_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_SETTLE,
    ST_GATE,
    ST_EVAL,
    ST_HOLD
  } state_t;

  typedef logic [1:0] range_t;

  // Defaults also used by the frequency-scaling stage: freq = count*CLK_HZ/(GATE_BASE<<range)
  localparam int unsigned SETTLE_CLKS_DEF = 4;
  localparam int unsigned GATE_BASE_DEF   = 200;
  localparam int unsigned MAX_RANGE_DEF   = 3;
  localparam int unsigned LOW_THRESH_DEF  = 16;
  localparam int unsigned HIGH_THRESH_DEF = 64;
  localparam int unsigned CNT_W_DEF       = 17;

  // Gate window length in clk cycles for a given range index.
  function automatic int unsigned gate_cycles(input int unsigned base, input range_t r);
    return base << r;
  endfunction

endpackage

// File: rtl/gated_edge_counter.sv
// rtl/gated_edge_counter.sv - synchronizer, rising-edge detect and saturating gated edge counter
module gated_edge_counter #(
  parameter int unsigned CNT_W = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig,
  input  logic             clear,
  input  logic             gate_en,
  output logic [CNT_W-1:0] edge_cnt,
  output logic [CNT_W-1:0] gate_cnt,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0] sync_q;
  logic       prev_q;
  logic       edge_det;

  // prev always follows the synchronized level, so a mux switch during settle never looks like an edge
  assign edge_det = sync_q[1] & ~prev_q;

  // Synchronize the muxed input, then count edges and gate cycles only while the gate is open
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      edge_cnt <= '0;
      gate_cnt <= '0;
      sat      <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], sig};
      prev_q <= sync_q[1];
      if (clear) begin
        edge_cnt <= '0;
        gate_cnt <= '0;
        sat      <= 1'b0;
      end else if (gate_en) begin
        gate_cnt <= gate_cnt + 1'b1;
        if (edge_det && edge_cnt != CNT_MAX) begin
          edge_cnt <= edge_cnt + 1'b1;
          if (edge_cnt == CNT_MAX - 1'b1) sat <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/freq_meas_scheduler.sv
// rtl/freq_meas_scheduler.sv - round-robin gated frequency measurement scheduler with per-channel auto-ranging
module freq_meas_scheduler
  import freq_meas_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CH_W        = 2,
  parameter int unsigned SETTLE_CLKS = SETTLE_CLKS_DEF,
  parameter int unsigned GATE_BASE   = GATE_BASE_DEF,
  parameter int unsigned MAX_RANGE   = MAX_RANGE_DEF,
  parameter int unsigned LOW_THRESH  = LOW_THRESH_DEF,
  parameter int unsigned HIGH_THRESH = HIGH_THRESH_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [NUM_CH-1:0] signal_in,
  input  logic              result_ready,
  output logic              result_valid,
  output logic [CH_W-1:0]   result_ch,
  output logic [CNT_W-1:0]  result_count,
  output logic [1:0]        result_range,
  output logic              result_sat,
  output logic              busy,
  output logic [CH_W-1:0]   cur_ch
);

  localparam int unsigned SET_W = (SETTLE_CLKS > 1) ? $clog2(SETTLE_CLKS) : 1;

  state_t            state_q, state_d;
  range_t            range_tbl [NUM_CH];
  range_t            cur_range;
  logic [CH_W-1:0]   last_ch, sel_ch;
  logic [CNT_W-1:0]  gate_len, edge_cnt, gate_cnt;
  logic [SET_W-1:0]  settle_cnt;
  logic              cnt_clear, cnt_gate, cnt_sat;
  logic              under, over, can_up, any_ch;

  assign busy      = (state_q != ST_IDLE);
  assign any_ch    = |ch_mask;
  assign cur_range = range_tbl[cur_ch];
  assign under     = edge_cnt < CNT_W'(LOW_THRESH);
  assign over      = edge_cnt > CNT_W'(HIGH_THRESH);
  assign can_up    = cur_range < range_t'(MAX_RANGE);
  assign cnt_clear = (state_q == ST_SETTLE);
  assign cnt_gate  = (state_q == ST_GATE);

  gated_edge_counter #(.CNT_W(CNT_W)) u_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .sig      (signal_in[cur_ch]),
    .clear    (cnt_clear),
    .gate_en  (cnt_gate),
    .edge_cnt (edge_cnt),
    .gate_cnt (gate_cnt),
    .sat      (cnt_sat)
  );

  // Round-robin pick: nearest enabled channel after last_ch, wrapping; a lone channel picks itself
  always_comb begin
    int unsigned idx;
    sel_ch = last_ch;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = (int'(last_ch) + i) % NUM_CH;
      if (ch_mask[CH_W'(idx)]) sel_ch = CH_W'(idx);
    end
  end

  // Next-state logic; run low aborts everything except a pending result handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (run && any_ch) state_d = ST_SELECT;
      ST_SELECT: state_d = (run && any_ch) ? ST_SETTLE : ST_IDLE;
      ST_SETTLE: begin
        if (!run) state_d = ST_IDLE;
        else if (settle_cnt == SET_W'(SETTLE_CLKS - 1)) state_d = ST_GATE;
      end
      ST_GATE: begin
        if (!run) state_d = ST_IDLE;
        else if (gate_cnt == gate_len - 1'b1) state_d = ST_EVAL;
      end
      ST_EVAL: begin
        if (!run) state_d = ST_IDLE;
        else if (under && can_up) state_d = ST_SETTLE;
        else state_d = ST_HOLD;
      end
      ST_HOLD:   if (result_ready) state_d = (run && any_ch) ? ST_SELECT : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State register, channel/gate setup, range table updates and the held result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cur_ch       <= '0;
      last_ch      <= CH_W'(NUM_CH - 1);
      gate_len     <= '0;
      settle_cnt   <= '0;
      result_valid <= 1'b0;
      result_ch    <= '0;
      result_count <= '0;
      result_range <= '0;
      result_sat   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) range_tbl[i] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_SELECT: if (state_d == ST_SETTLE) begin
          cur_ch     <= sel_ch;
          gate_len   <= CNT_W'(gate_cycles(GATE_BASE, range_tbl[sel_ch]));
          settle_cnt <= '0;
        end
        ST_SETTLE: settle_cnt <= settle_cnt + 1'b1;
        ST_EVAL: begin
          if (state_d == ST_SETTLE) begin
            range_tbl[cur_ch] <= cur_range + 1'b1;
            gate_len          <= CNT_W'(gate_cycles(GATE_BASE, cur_range + 1'b1));
            settle_cnt        <= '0;
          end else if (state_d == ST_HOLD) begin
            result_valid <= 1'b1;
            result_ch    <= cur_ch;
            result_count <= edge_cnt;
            result_range <= cur_range;
            result_sat   <= cnt_sat;
            last_ch      <= cur_ch;
            // The reported range is the one used; the step down applies to the next visit
            if (over && cur_range != '0) range_tbl[cur_ch] <= cur_range - 1'b1;
          end
        end
        ST_HOLD: if (result_ready) result_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meas_scheduler.sv
// tb/tb_freq_meas_scheduler.sv - randomized self-checking bench for freq_meas_scheduler
module tb_freq_meas_scheduler;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int CNT_W  = 17;
  localparam int SETTLE = 4;
  localparam int BASE   = 200;
  localparam int LOW    = 16;
  localparam int HIGH   = 64;
  localparam int MAXR   = 3;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              run = 1'b0;
  logic              result_ready = 1'b0;
  logic [NUM_CH-1:0] ch_mask = '0;
  logic [NUM_CH-1:0] signal_in = '0;
  logic              result_valid;
  logic [CH_W-1:0]   result_ch;
  logic [CNT_W-1:0]  result_count;
  logic [1:0]        result_range;
  logic              result_sat;
  logic              busy;
  logic [CH_W-1:0]   cur_ch;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int per [NUM_CH] = '{10, 10, 10, 10};
  int ph  [NUM_CH] = '{0, 3, 7, 1};
  int ptab [9] = '{2, 4, 5, 8, 10, 20, 25, 40, 50};

  // reference model state
  int m_range [NUM_CH] = '{0, 0, 0, 0};
  int m_last = NUM_CH - 1;
  bit m_idle = 1'b1;
  bit active = 1'b0;
  bit zero_chk = 1'b0;
  bit prev_valid = 1'b0;
  int sel_cyc, e_ch, e_cnt, e_rng, e_lat, e_next, e_sat;

  freq_meas_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .ch_mask      (ch_mask),
    .signal_in    (signal_in),
    .result_ready (result_ready),
    .result_valid (result_valid),
    .result_ch    (result_ch),
    .result_count (result_count),
    .result_range (result_range),
    .result_sat   (result_sat),
    .busy         (busy),
    .cur_ch       (cur_ch)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin : sig_gen
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_CH; i++)
        signal_in[i] = ((cyc + ph[i]) % per[i]) < (per[i] / 2);
    end
  end

  function automatic void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Whole measurement predicted at SELECT: channel pick, auto-range retries, latency, next range.
  function automatic void start_meas(input int k);
    int c, r, cnt, g;
    c = m_last;
    for (int i = 1; i <= NUM_CH; i++) begin
      if (ch_mask[(m_last + i) % NUM_CH]) begin
        c = (m_last + i) % NUM_CH;
        break;
      end
    end
    r = m_range[c];
    g = BASE * (1 << r);
    cnt = g / per[c];
    e_lat = 1 + SETTLE + g + 1;
    while (cnt < LOW && r < MAXR) begin
      r++;
      g = BASE * (1 << r);
      cnt = g / per[c];
      e_lat += SETTLE + g + 1;
    end
    e_sat = (cnt >= CMAX);
    if (cnt > CMAX) cnt = CMAX;
    e_ch = c;
    e_cnt = cnt;
    e_rng = r;
    e_next = (cnt > HIGH && r > 0) ? r - 1 : r;
    sel_cyc = k + 1;
    active = 1'b1;
  endfunction

  initial begin : compare
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        if (zero_chk) begin
          chk("rst_valid", result_valid, 0);
          chk("rst_busy", busy, 0);
          chk("rst_cur_ch", cur_ch, 0);
          chk("rst_res_ch", result_ch, 0);
          chk("rst_count", result_count, 0);
          chk("rst_range", result_range, 0);
          chk("rst_sat", result_sat, 0);
          zero_chk = 1'b0;
        end else begin
          chk("busy", busy, !m_idle);
        end
        if (!rst_n) begin
          foreach (m_range[i]) m_range[i] = 0;
          m_last = NUM_CH - 1;
          m_idle = 1'b1;
          active = 1'b0;
          zero_chk = 1'b1;
          prev_valid = 1'b0;
        end else begin
          if (result_valid && !prev_valid) begin
            if (!active) begin
              errs++;
              checks++;
              $display("FAIL spurious_valid: result_valid=1 with no measurement expected (cycle %0d)", cyc);
            end else begin
              chk("res_ch", result_ch, e_ch);
              chk("res_count", result_count, e_cnt);
              chk("res_range", result_range, e_rng);
              chk("res_sat", result_sat, e_sat);
              chk("res_latency", cyc - sel_cyc, e_lat);
              m_range[e_ch] = e_next;
              m_last = e_ch;
            end
          end else if (result_valid) begin
            chk("hold_ch", result_ch, e_ch);
            chk("hold_count", result_count, e_cnt);
            chk("hold_range", result_range, e_rng);
          end else if (active && cyc - sel_cyc == e_lat) begin
            errs++;
            checks++;
            $display("FAIL res_missing: result_valid=0, expected 1 at cycle %0d", cyc);
          end
          if (active && cyc > sel_cyc) chk("cur_ch", cur_ch, e_ch);
          if (result_valid && result_ready) begin
            active = 1'b0;
            if (run && ch_mask != 0) start_meas(cyc);
            else m_idle = 1'b1;
          end else if (m_idle && run && ch_mask != 0) begin
            m_idle = 1'b0;
            start_meas(cyc);
          end else if (!m_idle && !result_valid && !run) begin
            m_idle = 1'b1;
            active = 1'b0;
          end
          prev_valid = result_valid;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Wait for a result, optionally stall ready for d cycles, then handshake; returns captured fields.
  task automatic get_result(input int budget, input int d, input bit stop,
                            output int lat, output int rch, output int rcnt, output int rrng);
    int t0;
    bit got;
    t0 = cyc;
    got = 1'b0;
    lat = -1; rch = -1; rcnt = -1; rrng = -1;
    result_ready = (d == 0);
    for (int n = 0; n < budget && !got; n++) begin
      step(1);
      if (result_valid) got = 1'b1;
    end
    if (!got) begin
      errs++;
      checks++;
      $display("FAIL result_timeout: result_valid=0 after %0d cycles, expected 1", budget);
      run = 1'b0;
      result_ready = 1'b0;
      return;
    end
    lat = cyc - t0;
    rch = result_ch;
    rcnt = result_count;
    rrng = result_range;
    if (d > 0) begin
      step(d);
      chk("hold_still_valid", result_valid, 1);
      result_ready = 1'b1;
    end
    if (stop) run = 1'b0;
    step(1);
    result_ready = 1'b0;
    chk("valid_drop", result_valid, 0);
  endtask

  task automatic expect_result(input string tag, input int d, input bit stop,
                               input int x_lat, input int x_ch, input int x_cnt, input int x_rng);
    int lat, rch, rcnt, rrng;
    get_result(5000, d, stop, lat, rch, rcnt, rrng);
    if (x_lat >= 0) chk({tag, "_lat"}, lat, x_lat);
    chk({tag, "_ch"}, rch, x_ch);
    chk({tag, "_cnt"}, rcnt, x_cnt);
    chk({tag, "_rng"}, rrng, x_rng);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int seq [6] = '{1, 3, 0, 1, 3, 0};
    int lat, rch, rcnt, rrng, n;
    for (int i = 0; i < NUM_CH; i++) ph[i] = $urandom_range(0, 199);
    step(5);
    chk("init_busy", busy, 0);
    chk("init_valid", result_valid, 0);
    rst_n = 1'b1;
    step(3);

    // single channel, period 10: one result 206 cycles after SELECT
    ch_mask = 4'b0001;
    run = 1'b1;
    expect_result("p10", 0, 1, 207, 0, 20, 0);
    step(4);

    // period 40: two up-range retries then a single range-2 result
    per[0] = 40;
    run = 1'b1;
    expect_result("p40", 0, 1, 1417, 0, 20, 2);
    step(4);

    // period 2 starting at range 2: over-range steps down for the next visit
    per[0] = 2;
    run = 1'b1;
    expect_result("p2a", 0, 0, 807, 0, 400, 2);
    expect_result("p2b", 0, 1, 406, 0, 200, 1);
    step(4);

    // mask 1011: round robin skips ch2, starting after last_ch=0
    per = '{10, 10, 10, 10};
    ch_mask = 4'b1011;
    run = 1'b1;
    for (int j = 0; j < 6; j++)
      expect_result("rr", 0, j == 5, (j == 0) ? 207 : 206, seq[j], 20, 0);
    step(4);

    // ready held low 500 cycles, then a one-cycle handshake releases the next SELECT
    run = 1'b1;
    expect_result("stall", 500, 0, 207, 1, 20, 0);
    expect_result("after_stall", 0, 1, 206, 3, 20, 0);
    step(4);

    // abort mid-gate: no result, idle next cycle
    ch_mask = 4'b0001;
    run = 1'b1;
    step(50);
    run = 1'b0;
    step(1);
    chk("abort_busy", busy, 0);
    step(300);
    chk("abort_valid", result_valid, 0);

    // range table survives abort, then reset mid-gate clears it
    per[0] = 40;
    run = 1'b1;
    expect_result("pre_rst", 0, 1, 1417, 0, 20, 2);
    step(4);
    run = 1'b1;
    step(100);
    rst_n = 1'b0;
    run = 1'b0;
    step(1);
    rst_n = 1'b1;
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", result_valid, 0);
    chk("midrst_cur_ch", cur_ch, 0);
    step(5);
    run = 1'b1;
    expect_result("post_rst", 0, 1, 1417, 0, 20, 2);
    step(4);

    // randomized masks, periods, phases and ready stalls against the model
    for (int it = 0; it < 5; it++) begin
      ch_mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < NUM_CH; i++) begin
        per[i] = ptab[$urandom_range(0, 8)];
        ph[i] = $urandom_range(0, 99);
      end
      step(3);
      run = 1'b1;
      n = $urandom_range(2, 4);
      for (int j = 0; j < n; j++)
        get_result(5000, $urandom_range(0, 3), j == n - 1, lat, rch, rcnt, rrng);
      step(4);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
